// File: rtl/video_timing_counter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | video_timing_counter_if                                          |
// | Control inputs and raster-position outputs of the timing counter |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface video_timing_counter_if #(
  parameter int FRAME_W = 8
);
  logic               en;
  logic               restart;
  logic [11:0]        HCNT;
  logic [10:0]        VCNT;
  logic               line_start;
  logic               frame_start;
  logic               frame_end;
  logic               active;
  logic [FRAME_W-1:0] frame_cnt;

  modport master (
    output en, restart,
    input  HCNT, VCNT, line_start, frame_start, frame_end, active, frame_cnt
  );

  modport slave (
    input  en, restart,
    output HCNT, VCNT, line_start, frame_start, frame_end, active, frame_cnt
  );
endinterface
`default_nettype wire

// File: rtl/video_timing_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | video_timing_counter                                             |
// | Free-running raster position counters with line/frame strobes.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module video_timing_counter #(
  parameter int TOTAL_H  = 2200,
  parameter int ACTIVE_H = 1920,
  parameter int TOTAL_V  = 1125,
  parameter int ACTIVE_V = 1080,
  parameter int FRAME_W  = 8
) (
  input  wire logic             iCLK,
  input  wire logic             reset,
  video_timing_counter_if.slave vt
);

  localparam logic [11:0] c_H_LAST   = 12'(TOTAL_H - 1);
  localparam logic [10:0] c_V_LAST   = 11'(TOTAL_V - 1);
  localparam logic [11:0] c_ACTIVE_H = 12'(ACTIVE_H);
  localparam logic [10:0] c_ACTIVE_V = 11'(ACTIVE_V);

  logic [11:0]        hcnt_q, hcnt_d;
  logic [10:0]        vcnt_q, vcnt_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  logic               frame_end_q, frame_end_d;
  logic               active_q, active_d;

  always_comb begin
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    frame_cnt_d   = frame_cnt_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (vt.restart) begin
      hcnt_d        = '0;
      vcnt_d        = '0;
      line_start_d  = 1'b1;
      frame_start_d = 1'b1;
    end else if (vt.en) begin
      if (hcnt_q == c_H_LAST) begin
        hcnt_d       = '0;
        line_start_d = 1'b1;
        if (vcnt_q == c_V_LAST) begin
          vcnt_d        = '0;
          frame_start_d = 1'b1;
          frame_cnt_d   = frame_cnt_q + FRAME_W'(1);
        end else begin
          vcnt_d = vcnt_q + 11'd1;
        end
      end else begin
        hcnt_d = hcnt_q + 12'd1;
      end
    end

    // Decoded from the next position so the flags line up with HCNT/VCNT.
    active_d    = (hcnt_d < c_ACTIVE_H) && (vcnt_d < c_ACTIVE_V);
    frame_end_d = (hcnt_d == c_H_LAST) && (vcnt_d == c_V_LAST);
  end

  always_ff @(posedge iCLK) begin
    if (reset) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      frame_cnt_q   <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      active_q      <= 1'b1;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      frame_cnt_q   <= frame_cnt_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      active_q      <= active_d;
    end
  end

  assign vt.HCNT        = hcnt_q;
  assign vt.VCNT        = vcnt_q;
  assign vt.frame_cnt   = frame_cnt_q;
  assign vt.line_start  = line_start_q;
  assign vt.frame_start = frame_start_q;
  assign vt.frame_end   = frame_end_q;
  assign vt.active      = active_q;

endmodule
`default_nettype wire
